// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM-stage controller.
// State and op encodings plus the alignment-mask helper.
package mem_stage_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    ERR
  } state_e;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_e;

  function automatic logic [31:0] align_mask(input int dw);
    return 32'((dw / 8) - 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for hit/miss statistics.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues loads/stores, stalls the pipe,
// tracks dump/halt, access errors and hit/miss statistics.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 63,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              dump,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              halt,
  output logic              err,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [DATA_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_rd,
  output logic              m_wr,
  output logic              m_createdump,
  input  logic [DATA_W-1:0] m_dout,
  input  logic              m_done,
  input  logic              m_stall,
  input  logic              m_hit,
  input  logic              m_err
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [DATA_W-1:0] AMASK =
    DATA_W'(align_mask(DATA_W));

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              halt_q, halt_d;
  logic [WCW-1:0]    wait_q, wait_d;

  logic req, misalign, dump_go, issue_go;
  logic complete, hit_inc, miss_inc;

  assign req      = mem_rd | mem_wr;
  assign misalign = |(addr & AMASK);
  // halt_q gates the dump so a held halt instruction strobes once
  assign dump_go  = (state_q == IDLE) & dump & ~req & ~halt_q;
  assign issue_go = (state_q == ISSUE) & ~m_stall;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    halt_d   = halt_q | dump_go;
    wait_d   = wait_q;
    complete = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (mem_rd && mem_wr) begin
          state_d = ERR;
        end else if (req) begin
          if (misalign) begin
            state_d = ERR;
          end else begin
            state_d = ISSUE;
            op_d    = mem_rd ? OP_RD : OP_WR;
            addr_d  = addr;
            wdata_d = wdata;
          end
        end
      end
      (state_q == ISSUE): begin
        if (!m_stall) begin
          if (m_err) begin
            state_d = ERR;
          end else if (m_done) begin
            complete = 1'b1;
          end else begin
            state_d = WAIT;
            wait_d  = '0;
          end
        end
      end
      (state_q == WAIT): begin
        if (m_err) begin
          state_d = ERR;
        end else if (m_done) begin
          complete = 1'b1;
        end else if (wait_q == WCW'(MAX_WAIT - 1)) begin
          state_d = ERR;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      (state_q == RESP): state_d = IDLE;
      (state_q == ERR):  state_d = ERR;
      default:           state_d = IDLE;
    endcase
    if (complete) begin
      state_d = RESP;
      if (op_q == OP_RD) begin
        rdata_d = m_dout;
      end
    end
  end

  assign hit_inc  = complete & m_hit;
  assign miss_inc = complete & ~m_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      halt_q  <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      halt_q  <= halt_d;
      wait_q  <= wait_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_hit (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_cnt)
  );

  sat_counter #(.W(CNT_W)) u_miss (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (miss_cnt)
  );

  assign err          = (state_q == ERR);
  assign halt         = halt_q | err;
  assign stall        = ((state_q == IDLE) & req) |
                        (state_q == ISSUE) |
                        (state_q == WAIT) | err;
  assign rdata        = rdata_q;
  assign m_addr       = addr_q;
  assign m_wdata      = wdata_q;
  assign m_rd         = issue_go & (op_q == OP_RD);
  assign m_wr         = issue_go & (op_q == OP_WR);
  assign m_createdump = dump_go;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with short timeout
// and 4-bit counters so saturation is reachable.
module tb_mem_stage_ctrl;

  localparam int DW = 16;
  localparam int MW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_rd = 1'b0, mem_wr = 1'b0, dump = 1'b0;
  logic [DW-1:0] addr = '0, wdata = '0;
  logic [DW-1:0] rdata, m_addr, m_wdata;
  logic          stall, halt, err, m_rd, m_wr, m_createdump;
  logic [CW-1:0] hit_cnt, miss_cnt;
  logic [DW-1:0] m_dout = '0;
  logic          m_done = 1'b0, m_stall = 1'b0;
  logic          m_hit = 1'b0, m_err = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage_ctrl #(
    .DATA_W   (DW),
    .MAX_WAIT (MW),
    .CNT_W    (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .addr         (addr),
    .wdata        (wdata),
    .dump         (dump),
    .rdata        (rdata),
    .stall        (stall),
    .halt         (halt),
    .err          (err),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_rd         (m_rd),
    .m_wr         (m_wr),
    .m_createdump (m_createdump),
    .m_dout       (m_dout),
    .m_done       (m_done),
    .m_stall      (m_stall),
    .m_hit        (m_hit),
    .m_err        (m_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    dump    = 1'b0;
    m_done  = 1'b0;
    m_stall = 1'b0;
    m_hit   = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic load_hit(input logic [DW-1:0] a,
                          input logic [DW-1:0] d);
    mem_rd = 1'b1;
    addr   = a;
    m_done = 1'b1;
    m_hit  = 1'b1;
    m_dout = d;
    step();
    step();
    mem_rd = 1'b0;
    m_done = 1'b0;
    step();
  endtask

  initial begin
    do_reset();
    check("rst_rdata", 32'(rdata), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_halt",  32'(halt), 0);
    check("rst_err",   32'(err), 0);
    check("rst_hit",   32'(hit_cnt), 0);
    check("rst_miss",  32'(miss_cnt), 0);
    check("rst_strb",  32'({m_rd, m_wr, m_createdump}), 0);

    // load hit completing in the issue cycle
    mem_rd = 1'b1; addr = 16'h0010;
    m_done = 1'b1; m_hit = 1'b1; m_dout = 16'hBEEF;
    #1;
    check("ld_c0_stall", 32'(stall), 1);
    check("ld_c0_mrd",   32'(m_rd), 0);
    step();
    check("ld_c1_stall", 32'(stall), 1);
    check("ld_c1_mrd",   32'(m_rd), 1);
    check("ld_c1_maddr", 32'(m_addr), 'h10);
    step();
    check("ld_c2_stall", 32'(stall), 0);
    check("ld_c2_mrd",   32'(m_rd), 0);
    check("ld_rdata",    32'(rdata), 'hBEEF);
    check("ld_hit",      32'(hit_cnt), 1);
    mem_rd = 1'b0; m_done = 1'b0;
    step();

    // store with memory back-pressure, then a miss
    mem_wr = 1'b1; addr = 16'h0020; wdata = 16'h1234;
    m_stall = 1'b1; m_hit = 1'b0; m_dout = 16'h5555;
    #1;
    check("st_c0_stall", 32'(stall), 1);
    step();
    for (int i = 0; i < 3; i++) begin
      check("st_mstall_mwr", 32'(m_wr), 0);
      check("st_mstall_stall", 32'(stall), 1);
      step();
    end
    m_stall = 1'b0;
    #1;
    check("st_mwr",    32'(m_wr), 1);
    check("st_mwdata", 32'(m_wdata), 'h1234);
    check("st_maddr",  32'(m_addr), 'h20);
    step();
    for (int i = 0; i < 3; i++) begin
      check("st_wait_mwr", 32'(m_wr), 0);
      check("st_wait_stall", 32'(stall), 1);
      step();
    end
    m_done = 1'b1;
    #1;
    check("st_done_stall", 32'(stall), 1);
    step();
    check("st_resp_stall", 32'(stall), 0);
    check("st_miss",       32'(miss_cnt), 1);
    check("st_hit",        32'(hit_cnt), 1);
    check("st_rdata",      32'(rdata), 'hBEEF);
    check("st_resp_mwd",   32'(m_wdata), 'h1234);
    check("st_err",        32'(err), 0);
    mem_wr = 1'b0; m_done = 1'b0;
    step();

    // dump with no request
    dump = 1'b1;
    #1;
    check("dmp_strobe", 32'(m_createdump), 1);
    check("dmp_stall",  32'(stall), 0);
    check("dmp_halt0",  32'(halt), 0);
    step();
    check("dmp_strobe1", 32'(m_createdump), 0);
    check("dmp_halt1",   32'(halt), 1);
    dump = 1'b0;
    step();
    check("dmp_halt2",  32'(halt), 1);
    check("dmp_stall2", 32'(stall), 0);
    check("dmp_err",    32'(err), 0);

    // misaligned load
    do_reset();
    mem_rd = 1'b1; addr = 16'h0011;
    #1;
    check("mis_mrd0", 32'(m_rd), 0);
    step();
    for (int i = 0; i < 3; i++) begin
      check("mis_mrd",   32'(m_rd), 0);
      check("mis_err",   32'(err), 1);
      check("mis_halt",  32'(halt), 1);
      check("mis_stall", 32'(stall), 1);
      step();
    end

    // simultaneous read and write
    do_reset();
    mem_rd = 1'b1; mem_wr = 1'b1; addr = 16'h0040;
    step();
    check("rw_err",  32'(err), 1);
    check("rw_strb", 32'({m_rd, m_wr}), 0);

    // timeout after MAX_WAIT wait cycles
    do_reset();
    mem_rd = 1'b1; addr = 16'h0030;
    step();
    step();
    for (int i = 0; i < MW; i++) begin
      check("to_wait_err", 32'(err), 0);
      check("to_wait_stall", 32'(stall), 1);
      step();
    end
    check("to_err",  32'(err), 1);
    check("to_halt", 32'(halt), 1);

    // m_err beats m_done in WAIT
    do_reset();
    mem_rd = 1'b1; addr = 16'h0030; m_dout = 16'h7777;
    step();
    step();
    m_err = 1'b1; m_done = 1'b1; m_hit = 1'b1;
    #1;
    check("me_pre_err", 32'(err), 0);
    step();
    check("me_err",   32'(err), 1);
    check("me_hit",   32'(hit_cnt), 0);
    check("me_rdata", 32'(rdata), 0);

    // reset asserted in WAIT
    do_reset();
    load_hit(16'h0002, 16'hAAAA);
    check("rw0_rdata", 32'(rdata), 'hAAAA);
    mem_rd = 1'b1; addr = 16'h0044;
    step();
    step();
    check("rw0_stall", 32'(stall), 1);
    #2;
    idle_inputs();
    rst = 1'b1;
    #1;
    check("arst_rdata", 32'(rdata), 0);
    check("arst_hit",   32'(hit_cnt), 0);
    check("arst_stall", 32'(stall), 0);
    check("arst_maddr", 32'(m_addr), 0);
    check("arst_flags", 32'({halt, err, m_rd, m_wr}), 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("arst_nore", 32'({m_rd, m_wr, stall}), 0);
    end

    // hit counter saturation
    do_reset();
    for (int i = 0; i < 14; i++) load_hit(16'h0008, 16'(i));
    check("sat_14", 32'(hit_cnt), 14);
    for (int i = 0; i < 4; i++) load_hit(16'h0008, 16'h00F0);
    check("sat_hold", 32'(hit_cnt), 15);
    check("sat_miss", 32'(miss_cnt), 0);
    check("sat_rdata", 32'(rdata), 'hF0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Parametrised memory-stage controller for the pipeline's MEM stage. It accepts one load or store per instruction from the execute/memory pipeline register and issues it to the data memory system (stallmem or mem_system interface). While the access is outstanding it stalls the pipeline and captures read data. It also owns dump/halt sequencing, access-error detection (misalignment, illegal op, memory error, timeout) and hit/miss statistics.

## Interface
- DATA_W, 16, data and address width (power of two, ≥ 16)
- MAX_WAIT, 63, cycles allowed in WAIT before timeout error
- CNT_W, 16, width of hit/miss statistic counters
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- mem_rd  in  1  pipeline load request
- mem_wr  in  1  pipeline store request
- addr  in  DATA_W  byte address (ALU result)
- wdata  in  DATA_W  store data
- dump  in  1  halt instruction in MEM; request memory dump
- rdata  out  DATA_W  last load data, held until the next load completes
- stall  out  1  hold the pipeline; current MEM instruction not finished
- halt  out  1  sticky; dump seen or error
- err  out  1  sticky access error
- hit_cnt  out  CNT_W  saturating count of cache hits
- miss_cnt  out  CNT_W  saturating count of cache misses
- m_addr, m_wdata  out  DATA_W  latched request to the memory system
- m_rd, m_wr  out  1  one-cycle request strobes
- m_createdump  out  1  one-cycle dump strobe
- m_dout  in  DATA_W  memory read data
- m_done, m_stall, m_hit, m_err  in  1  memory-system status

## Operation
- States: IDLE, ISSUE, WAIT, RESP, ERR.
- IDLE:
  - Exactly one of mem_rd/mem_wr, address aligned (low log2(DATA_W/8) bits zero) -> latch addr, wdata and op; go to ISSUE.
  - mem_rd & mem_wr -> ERR.
  - Misaligned address -> ERR; no memory access is issued.
  - dump with no request -> m_createdump=1 for that cycle; halt_q set; stay in IDLE.
- ISSUE:
  - m_stall=1 -> drive no strobe; stay in ISSUE.
  - Otherwise assert m_rd or m_wr for this cycle and go to WAIT.
  - If m_done is also high in that cycle, complete exactly as in WAIT (go to RESP).
- WAIT:
  - m_err -> ERR.
  - m_done -> on a load, rdata <= m_dout; hit_cnt++ if m_hit, else miss_cnt++; go to RESP.
  - Wait counter reaching MAX_WAIT -> ERR. Counter clears on entry to WAIT.
- RESP: stall=0 for one cycle, then IDLE. The pipeline advances at the end of RESP.
- ERR: err=1, halt=1, stall=1. Only reset leaves ERR.
- stall = (IDLE & (mem_rd | mem_wr)) | ISSUE | WAIT | ERR. This is combinational, so a new request stalls in the cycle it appears.
- halt = halt_q | err.
- Counters saturate at 2^CNT_W-1. m_err takes priority over m_done in the same cycle.
- Stores never modify rdata.
- Reset values: state IDLE; rdata, counters, halt_q, err, wait counter all 0; every strobe output 0.
- Reset asserted mid-access abandons the access. No strobe is re-issued after release.

## Timing
- Load hit with m_done in the issue cycle: cycle 0 IDLE (stall=1), cycle 1 ISSUE (m_rd=1, m_done=1), cycle 2 RESP (stall=0, rdata valid). Two stall cycles.
- Each cycle of m_stall in ISSUE and each cycle without m_done in WAIT adds one stall cycle.
- m_rd, m_wr and m_createdump are never high for more than one consecutive cycle per instruction.
- m_addr and m_wdata are registered and stable from ISSUE through RESP.
- Timeout: ERR is entered on the cycle after the MAX_WAIT-th WAIT cycle without m_done.

## Structure
- Package mem_stage_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, RESP, ERR);
  - op enum (OP_RD, OP_WR);
  - alignment-mask helper function of DATA_W.
- Sub-module sat_counter (parameter W; ports clk, rst, inc, count) is instantiated twice, for hits and misses.

## Test plan
- Load addr 0x0010 with m_done=1, m_hit=1 in the issue cycle, m_dout=0xBEEF -> m_rd pulse, stall high for 2 cycles, rdata=0xBEEF, hit_cnt=1.
- Store addr 0x0020, wdata 0x1234, m_stall=1 for 3 cycles, then m_done 4 cycles after m_wr -> single m_wr pulse after stall drops, m_wdata=0x1234, miss_cnt=1 (m_hit=0), rdata unchanged.
- Load addr 0x0011 -> no m_rd, err=1, halt=1, stall stays 1. Likewise mem_rd=mem_wr=1 -> err=1.
- MAX_WAIT=4, m_done never asserted -> ERR entered after 4 WAIT cycles; m_err pulse during WAIT -> ERR next cycle even if m_done is also high.
- dump with no request -> one m_createdump pulse, halt stays 1 afterward, stall=0.
- Reset asserted in WAIT -> all outputs 0 and state IDLE; 2^CNT_W+2 hits with CNT_W=4 -> hit_cnt holds at 15.
